// File: rtl/imem_loader_ctrl_pkg.sv
// Shared definitions for the instruction-memory loader and its neighbours
// (UART top, debug unit): FSM state encoding, run modes, command bytes and
// the opcode that terminates a program image.
package imem_loader_ctrl_pkg;

  // Command bytes received over the UART.
  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0] CMD_EXIT = 8'h45;  // 'E'

  // Opcode field (bits 31:26) of the instruction that ends a program.
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  // Bytes per instruction word on the serial link (big-endian order).
  localparam int WORD_BYTES = 4;

  // Controller state; the encoding is visible on state_dbg.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_STEP  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // How the pipeline is driven once START has reset it.
  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_STEP = 1'b1
  } run_mode_e;

endpackage

// File: rtl/imem_loader_ctrl_word_assembler.sv
// imem_word_assembler: collects big-endian bytes into 32-bit words.
// The first three bytes of a word are kept in a shift register; on the
// fourth byte the complete word is presented combinationally together with
// a one-cycle word_valid_o, so the caller can register it on that same edge
// and no byte is ever stalled.
//
// Ports:
//   clka         clock, rising edge
//   reset        synchronous active-high reset
//   clear_i      drop any partial word (start of a new load)
//   byte_valid_i byte_i carries a data byte this cycle
//   byte_i       data byte
//   word_valid_o this byte completes a word
//   word_o       {previous three bytes, byte_i}
module imem_word_assembler
  import imem_loader_ctrl_pkg::*;
(
  input  logic        clka,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  count_q, count_d;

  assign word_o       = {shift_q, byte_i};
  assign word_valid_o = byte_valid_i && (count_q == 2'(WORD_BYTES - 1));

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    if (clear_i) begin
      shift_d = '0;
      count_d = '0;
    end else if (byte_valid_i) begin
      shift_d = word_o[23:0];
      count_d = count_q + 2'd1;  // wraps to 0 after the fourth byte
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of process order.
  always_ff @(posedge clka) begin
    if (reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: loads a program from the UART byte stream into the
// instruction RAM, then runs the pipeline continuously or one cycle per
// step command until a halt instruction retires.
//
// Ports:
//   clka        clock, rising edge
//   reset       synchronous active-high reset; aborts load or run
//   rx_data     received UART byte
//   rx_valid    rx_data valid strobe (one cycle)
//   halt_in     halt instruction reached writeback
//   mem_addr    instruction RAM write address
//   mem_din     instruction RAM write data
//   mem_we      instruction RAM write enable, one pulse per word
//   cpu_en      pipeline/PC enable
//   cpu_rst     pipeline reset pulse
//   prog_loaded a halt-terminated program is resident
//   load_err    load filled the RAM without a halt word
//   done        program has halted
//   state_dbg   current state encoding
module imem_loader_ctrl
  import imem_loader_ctrl_pkg::*;
#(
  parameter int         RAM_WIDTH   = 32,
  parameter int         RAM_DEPTH   = 2048,
  parameter int         ADDR_WIDTH  = 11,
  parameter logic [5:0] HALT_OPCODE = imem_loader_ctrl_pkg::HALT_OPCODE
) (
  input  logic                  clka,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  halt_in,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [RAM_WIDTH-1:0]  mem_din,
  output logic                  mem_we,
  output logic                  cpu_en,
  output logic                  cpu_rst,
  output logic                  prog_loaded,
  output logic                  load_err,
  output logic                  done,
  output logic [2:0]            state_dbg
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_e                  state_q, state_d;
  run_mode_e               mode_q, mode_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [RAM_WIDTH-1:0]    din_q, din_d;
  logic                    we_q, we_d;
  logic                    loaded_q, loaded_d;
  logic                    err_q, err_d;
  logic                    step_pulse_q, step_pulse_d;

  logic                    asm_clear;
  logic                    word_valid;
  logic [31:0]             word;

  logic cmd_load, cmd_run, cmd_step, cmd_exit;

  assign cmd_load = rx_valid && (rx_data == CMD_LOAD);
  assign cmd_run  = rx_valid && (rx_data == CMD_RUN);
  assign cmd_step = rx_valid && (rx_data == CMD_STEP);
  assign cmd_exit = rx_valid && (rx_data == CMD_EXIT);

  // Only LOAD treats received bytes as data; elsewhere they are commands.
  imem_word_assembler u_asm (
    .clka         (clka),
    .reset        (reset),
    .clear_i      (asm_clear),
    .byte_valid_i (rx_valid && (state_q == ST_LOAD)),
    .byte_i       (rx_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    ptr_d        = ptr_q;
    addr_d       = addr_q;
    din_d        = din_q;
    we_d         = 1'b0;
    loaded_d     = loaded_q;
    err_d        = err_q;
    step_pulse_d = 1'b0;
    asm_clear    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_load) begin
          state_d   = ST_LOAD;
          ptr_d     = '0;
          loaded_d  = 1'b0;
          err_d     = 1'b0;
          asm_clear = 1'b1;
        end else if ((cmd_run || cmd_step) && loaded_q) begin
          state_d = ST_START;
          mode_d  = cmd_step ? MODE_STEP : MODE_RUN;
        end
      end

      ST_LOAD: begin
        if (word_valid) begin
          we_d   = 1'b1;
          din_d  = word;
          addr_d = ptr_q;
          ptr_d  = ptr_q + ADDR_WIDTH'(1);
          // A halt word is written like any other and closes the program;
          // a non-halt word in the last slot means the image does not fit.
          if (word[31:26] == HALT_OPCODE) begin
            state_d  = ST_IDLE;
            loaded_d = 1'b1;
          end else if (ptr_q == LAST_ADDR) begin
            state_d  = ST_IDLE;
            err_d    = 1'b1;
            loaded_d = 1'b0;
          end
        end
      end

      ST_START: begin
        state_d = (mode_q == MODE_STEP) ? ST_STEP : ST_RUN;
      end

      ST_RUN: begin
        if (halt_in) state_d = ST_DONE;
      end

      ST_STEP: begin
        // halt_in wins over a step command arriving in the same cycle.
        if (halt_in) begin
          state_d = ST_DONE;
        end else if (cmd_step) begin
          step_pulse_d = 1'b1;
        end else if (cmd_exit) begin
          state_d = ST_IDLE;
        end
      end

      ST_DONE: begin
        if (cmd_run) begin
          state_d = ST_START;
          mode_d  = MODE_RUN;
        end else if (cmd_step) begin
          state_d = ST_START;
          mode_d  = MODE_STEP;
        end else if (cmd_load) begin
          state_d   = ST_LOAD;
          ptr_d     = '0;
          loaded_d  = 1'b0;
          err_d     = 1'b0;
          asm_clear = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_RUN;
      ptr_q        <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      we_q         <= 1'b0;
      loaded_q     <= 1'b0;
      err_q        <= 1'b0;
      step_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      ptr_q        <= ptr_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      we_q         <= we_d;
      loaded_q     <= loaded_d;
      err_q        <= err_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign mem_addr    = addr_q;
  assign mem_din     = din_q;
  assign mem_we      = we_q;
  assign cpu_en      = (state_q == ST_RUN) || step_pulse_q;
  assign cpu_rst     = (state_q == ST_START);
  assign prog_loaded = loaded_q;
  assign load_err    = err_q;
  assign done        = (state_q == ST_DONE);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Testbench for imem_loader_ctrl. Inputs change and outputs are sampled on
// the falling clock edge. Expected write streams and flags come from a
// word-level model of the load rules applied to the program the bench sent.
module tb_imem_loader_ctrl;
  import imem_loader_ctrl_pkg::*;

  localparam int RAM_DEPTH  = 2048;
  localparam int ADDR_WIDTH = 11;

  logic        clka     = 1'b0;
  logic        reset    = 1'b1;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_valid = 1'b0;
  logic        halt_in  = 1'b0;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we, cpu_en, cpu_rst, prog_loaded, load_err, done;
  logic [2:0]  state_dbg;

  imem_loader_ctrl #(
    .RAM_WIDTH  (32),
    .RAM_DEPTH  (RAM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .clka        (clka),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .halt_in     (halt_in),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_we      (mem_we),
    .cpu_en      (cpu_en),
    .cpu_rst     (cpu_rst),
    .prog_loaded (prog_loaded),
    .load_err    (load_err),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  always #5 clka = ~clka;

  int n_checks = 0;
  int n_pass   = 0;
  int en_seen  = 0;
  int rst_seen = 0;
  logic [ADDR_WIDTH-1:0] wr_addr[$];
  logic [31:0]           wr_data[$];
  logic [31:0]           prog_words[$];

  // One clock: advance to the falling edge and record what the DUT shows.
  task automatic cycle();
    @(negedge clka);
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_din);
    end
    if (cpu_en === 1'b1) en_seen++;
    if (cpu_rst === 1'b1) rst_seen++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cycle();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  function automatic logic [31:0] rand_plain();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3F) w[26] = 1'b0;
    return w;
  endfunction

  function automatic logic [31:0] rand_halt();
    logic [31:0] w;
    w = $urandom;
    w[31:26] = 6'h3F;
    return w;
  endfunction

  task automatic send_words(input int max_gap);
    foreach (prog_words[i]) begin
      logic [31:0] w;
      w = prog_words[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[31-8*k -: 8]);
        if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) cycle();
      end
    end
    repeat (3) cycle();
  endtask

  task automatic load_prog(input int max_gap);
    wr_addr.delete();
    wr_data.delete();
    send_byte(CMD_LOAD);
    send_words(max_gap);
  endtask

  // Model: words are written to consecutive addresses from 0 until a halt
  // word (inclusive) or until the last RAM address is used.
  task automatic check_load(input string name);
    int exp_n;
    logic exp_prog, exp_err;
    int bad, lim;
    exp_n = 0; exp_prog = 1'b0; exp_err = 1'b0;
    for (int i = 0; i < prog_words.size(); i++) begin
      logic [31:0] w;
      w = prog_words[i];
      exp_n = i + 1;
      if (w[31:26] == 6'h3F) begin exp_prog = 1'b1; break; end
      if (i == RAM_DEPTH - 1) begin exp_err = 1'b1; break; end
    end
    n_checks++;
    if (wr_addr.size() != exp_n)
      $display("FAIL %s write count: got %0d expected %0d", name, wr_addr.size(), exp_n);
    else n_pass++;
    bad = 0;
    lim = (wr_addr.size() < exp_n) ? wr_addr.size() : exp_n;
    for (int i = 0; i < lim; i++) begin
      if (wr_addr[i] !== ADDR_WIDTH'(i) || wr_data[i] !== prog_words[i]) begin
        if (bad == 0)
          $display("FAIL %s write %0d: got addr %0d data %h expected addr %0d data %h",
                   name, i, wr_addr[i], wr_data[i], i, prog_words[i]);
        bad++;
      end
    end
    n_checks++;
    if (bad != 0 || lim == 0) begin
      if (lim == 0) $display("FAIL %s write contents: got no writes expected %0d", name, exp_n);
    end else n_pass++;
    n_checks++;
    if (prog_loaded !== exp_prog || load_err !== exp_err || state_dbg !== ST_IDLE)
      $display("FAIL %s flags: got loaded=%b err=%b state=%0d expected loaded=%b err=%b state=0",
               name, prog_loaded, load_err, state_dbg, exp_prog, exp_err);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; halt_in = 1'b0;
    repeat (3) cycle();
    n_checks++;
    if ({mem_we, cpu_en, cpu_rst, prog_loaded, load_err, done} !== 6'b0)
      $display("FAIL reset flags: got %b expected 000000",
               {mem_we, cpu_en, cpu_rst, prog_loaded, load_err, done});
    else n_pass++;
    n_checks++;
    if (mem_addr !== '0 || mem_din !== '0)
      $display("FAIL reset mem bus: got addr %0d din %h expected 0 0", mem_addr, mem_din);
    else n_pass++;
    n_checks++;
    if (state_dbg !== ST_IDLE) $display("FAIL reset state: got %0d expected 0", state_dbg);
    else n_pass++;
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_load_basic();
    prog_words.delete();
    prog_words.push_back(32'h20010005);
    prog_words.push_back(32'hFC000000);
    load_prog(2);
    check_load("load_basic");
  endtask

  task automatic test_back_to_back();
    prog_words.delete();
    repeat (3) prog_words.push_back(rand_plain());
    prog_words.push_back(rand_halt());
    load_prog(0);
    check_load("back_to_back");
  endtask

  task automatic test_random_load();
    for (int it = 0; it < 4; it++) begin
      int n;
      n = $urandom_range(6, 1);
      prog_words.delete();
      repeat (n - 1) prog_words.push_back(rand_plain());
      prog_words.push_back(rand_halt());
      load_prog(3);
      check_load($sformatf("random_load%0d", it));
    end
  endtask

  task automatic test_run();
    int en0, rst0;
    logic halted;
    en0 = en_seen; rst0 = rst_seen; halted = 1'b0;
    send_byte(CMD_RUN);
    n_checks++;
    if (cpu_rst !== 1'b1 || cpu_en !== 1'b0)
      $display("FAIL run start pulse: got rst=%b en=%b expected rst=1 en=0", cpu_rst, cpu_en);
    else n_pass++;
    for (int c = 0; c < 40; c++) begin
      int ne;
      ne = en_seen - en0;
      // Random bytes while running must be ignored.
      if (!halted && ne >= 1 && ne < 10) begin
        rx_valid = 1'($urandom_range(1, 0));
        rx_data  = 8'($urandom);
      end else rx_valid = 1'b0;
      cycle();
      rx_valid = 1'b0;
      if (!halted && (en_seen - en0) == 10) begin
        halt_in = 1'b1;
        halted  = 1'b1;
      end else halt_in = 1'b0;
    end
    halt_in = 1'b0;
    n_checks++;
    if (en_seen - en0 != 10) $display("FAIL run enable cycles: got %0d expected 10", en_seen - en0);
    else n_pass++;
    n_checks++;
    if (rst_seen - rst0 != 1) $display("FAIL run rst pulses: got %0d expected 1", rst_seen - rst0);
    else n_pass++;
    n_checks++;
    if (done !== 1'b1 || cpu_en !== 1'b0 || state_dbg !== ST_DONE)
      $display("FAIL run halted: got done=%b en=%b state=%0d expected 1 0 5", done, cpu_en, state_dbg);
    else n_pass++;
  endtask

  task automatic test_step();
    int en0, rst0;
    en0 = en_seen; rst0 = rst_seen;
    send_byte(CMD_STEP);
    n_checks++;
    if (cpu_rst !== 1'b1 || cpu_en !== 1'b0)
      $display("FAIL step start pulse: got rst=%b en=%b expected rst=1 en=0", cpu_rst, cpu_en);
    else n_pass++;
    cycle();
    n_checks++;
    if (state_dbg !== ST_STEP || cpu_en !== 1'b0 || done !== 1'b0)
      $display("FAIL step entry: got state=%0d en=%b done=%b expected 4 0 0", state_dbg, cpu_en, done);
    else n_pass++;
    for (int s = 0; s < 3; s++) begin
      repeat ($urandom_range(2, 0)) cycle();
      send_byte(CMD_STEP);
      n_checks++;
      if (cpu_en !== 1'b1) $display("FAIL step pulse %0d: got en=%b expected 1", s, cpu_en);
      else n_pass++;
    end
    send_byte(CMD_EXIT);
    cycle();
    n_checks++;
    if (state_dbg !== ST_IDLE || cpu_en !== 1'b0)
      $display("FAIL step exit: got state=%0d en=%b expected 0 0", state_dbg, cpu_en);
    else n_pass++;
    n_checks++;
    if (en_seen - en0 != 3 || rst_seen - rst0 != 1)
      $display("FAIL step counts: got en=%0d rst=%0d expected en=3 rst=1", en_seen - en0, rst_seen - rst0);
    else n_pass++;
  endtask

  task automatic test_step_halt_priority();
    int en0;
    send_byte(CMD_STEP);
    cycle();
    en0 = en_seen;
    halt_in = 1'b1;
    send_byte(CMD_STEP);
    halt_in = 1'b0;
    cycle();
    n_checks++;
    if (en_seen - en0 != 0 || done !== 1'b1 || state_dbg !== ST_DONE)
      $display("FAIL step halt priority: got en=%0d done=%b state=%0d expected 0 1 5",
               en_seen - en0, done, state_dbg);
    else n_pass++;
  endtask

  task automatic test_done_commands();
    send_byte(8'h41);
    cycle();
    n_checks++;
    if (state_dbg !== ST_DONE) $display("FAIL done ignore byte: got state=%0d expected 5", state_dbg);
    else n_pass++;
    send_byte(CMD_RUN);
    n_checks++;
    if (cpu_rst !== 1'b1 || done !== 1'b0)
      $display("FAIL done rerun: got rst=%b done=%b expected 1 0", cpu_rst, done);
    else n_pass++;
    cycle();
    halt_in = 1'b1;
    cycle();
    halt_in = 1'b0;
    n_checks++;
    if (state_dbg !== ST_DONE) $display("FAIL done rehalt: got state=%0d expected 5", state_dbg);
    else n_pass++;
    wr_addr.delete();
    wr_data.delete();
    send_byte(CMD_LOAD);
    n_checks++;
    if (state_dbg !== ST_LOAD || prog_loaded !== 1'b0 || done !== 1'b0)
      $display("FAIL done load: got state=%0d loaded=%b done=%b expected 1 0 0",
               state_dbg, prog_loaded, done);
    else n_pass++;
    prog_words.delete();
    prog_words.push_back(rand_plain());
    prog_words.push_back(rand_halt());
    send_words(1);
    check_load("done_reload");
  endtask

  task automatic test_overflow();
    int rst0;
    prog_words.delete();
    repeat (RAM_DEPTH) prog_words.push_back(rand_plain());
    load_prog(0);
    check_load("overflow");
    n_checks++;
    if (wr_addr.size() == 0 || wr_addr[wr_addr.size()-1] !== ADDR_WIDTH'(RAM_DEPTH - 1))
      $display("FAIL overflow last addr: got %0d expected %0d",
               (wr_addr.size() == 0) ? -1 : int'(wr_addr[wr_addr.size()-1]), RAM_DEPTH - 1);
    else n_pass++;
    rst0 = rst_seen;
    send_byte(CMD_RUN);
    repeat (3) cycle();
    n_checks++;
    if (state_dbg !== ST_IDLE || rst_seen != rst0 || cpu_en !== 1'b0)
      $display("FAIL overflow run ignored: got state=%0d rst=%0d en=%b expected 0 0 0",
               state_dbg, rst_seen - rst0, cpu_en);
    else n_pass++;
  endtask

  task automatic test_reset_midload();
    send_byte(CMD_LOAD);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    reset = 1'b1;
    cycle();
    n_checks++;
    if (state_dbg !== ST_IDLE || mem_we !== 1'b0 || load_err !== 1'b0 || prog_loaded !== 1'b0)
      $display("FAIL reset midload: got state=%0d we=%b err=%b loaded=%b expected 0 0 0 0",
               state_dbg, mem_we, load_err, prog_loaded);
    else n_pass++;
    reset = 1'b0;
    cycle();
    prog_words.delete();
    prog_words.push_back(rand_plain());
    prog_words.push_back(rand_halt());
    load_prog(1);
    check_load("reload_after_reset");
    send_byte(CMD_RUN);
    repeat (4) cycle();
    n_checks++;
    if (cpu_en !== 1'b1) $display("FAIL rerun before reset: got en=%b expected 1", cpu_en);
    else n_pass++;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_checks++;
    if (cpu_en !== 1'b0 || state_dbg !== ST_IDLE || prog_loaded !== 1'b0)
      $display("FAIL reset midrun: got en=%b state=%0d loaded=%b expected 0 0 0",
               cpu_en, state_dbg, prog_loaded);
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_basic();
    test_back_to_back();
    test_random_load();
    test_run();
    test_step();
    test_step_halt_priority();
    test_done_commands();
    test_overflow();
    test_reset_midload();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
